// File: rtl/seq_bw_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, signed (Baugh-Wooley) or unsigned, one partial product per cycle.
// Latency: WIDTH cycles from the accept edge to out_valid. Initiation interval is at least WIDTH+1 cycles.
// Backpressure: p and out_valid hold in DONE until out_ready. in_ready is high only in IDLE.
module seq_bw_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p,
   output logic                 busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [PW-1:0]    CORR     = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
   localparam logic [CW-1:0]    LAST_K   = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              sm_q;
   logic [CW-1:0]     cnt;
   logic [PW-1:0]     acc;

   logic              last_k;
   logic              bit_k;
   logic [WIDTH-1:0]  row;
   logic [PW-1:0]     row_sh;
   logic [PW-1:0]     acc_sum;

   // In signed mode, bits with exactly one operand MSB are inverted; the constant fixes up the sum.
   always_comb begin
      last_k = (cnt == LAST_K);
      bit_k  = b_q[cnt];
      row    = a_q & {WIDTH{bit_k}};
      if (sm_q) begin
         row = row ^ (last_k ? ~MSB_ONLY : MSB_ONLY);
      end
      row_sh  = {{WIDTH{1'b0}}, row} << cnt;
      acc_sum = acc + row_sh + ((sm_q && last_k) ? CORR : '0);
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (last_k) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            in_ready  = 1'b1;
            busy      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         sm_q <= 1'b0;
         cnt  <= '0;
         acc  <= '0;
         p    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q  <= a;
                  b_q  <= b;
                  sm_q <= signed_mode;
                  cnt  <= '0;
                  acc  <= '0;
               end
            end
            CALC: begin
               acc <= acc_sum;
               if (last_k) begin
                  p <= acc_sum;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bw_multiplier.sv
// Bench for seq_bw_multiplier at WIDTH=4 and WIDTH=8; expected products are queued at accept and popped at output.
module tb_seq_bw_multiplier;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        iv4, ir4, sm4, ov4, or4, busy4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;
   logic        iv8, ir8, sm8, ov8, or8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int checks = 0;
   int errors = 0;
   logic [7:0]  q4[$];
   logic [15:0] q8[$];

   seq_bw_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .p(p4), .busy(busy4)
   );

   seq_bw_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
   );

   function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic sm);
      logic signed [15:0] sx, sy;
      logic [15:0] ux, uy;
      sx = $signed(x);
      sy = $signed(y);
      ux = {8'h00, x};
      uy = {8'h00, y};
      return sm ? 16'(sx * sy) : 16'(ux * uy);
   endfunction

   // Drives operands until an accept edge; leaves the bench 1 time unit after that edge.
   task automatic accept4(input logic [3:0] ta, input logic [3:0] tb, input logic tsm,
                          input logic [7:0] exp, input bit keep, output bit ok);
      bit rdy;
      a4 = ta; b4 = tb; sm4 = tsm; iv4 = 1'b1; ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk); rdy = ir4;
         @(posedge clk); #1;
         if (rdy) ok = 1'b1;
      end
      if (!keep) iv4 = 1'b0;
      if (ok) q4.push_back(exp);
   endtask

   task automatic accept8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                          input logic [15:0] exp, output bit ok);
      bit rdy;
      a8 = ta; b8 = tb; sm8 = tsm; iv8 = 1'b1; ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk); rdy = ir8;
         @(posedge clk); #1;
         if (rdy) ok = 1'b1;
      end
      iv8 = 1'b0;
      if (ok) q8.push_back(exp);
   endtask

   // Counts rising edges until out_valid is seen at a falling edge; -1 on timeout.
   task automatic wait_out4(output int n);
      n = -1;
      for (int i = 1; i <= 40 && n < 0; i++) begin
         @(posedge clk); @(negedge clk);
         if (ov4) n = i;
      end
   endtask

   task automatic wait_out8(output int n);
      n = -1;
      for (int i = 1; i <= 40 && n < 0; i++) begin
         @(posedge clk); @(negedge clk);
         if (ov8) n = i;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      iv4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; or4 = 1'b1;
      iv8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; or8 = 1'b1;
      #12;
      checks++;
      if ({ir4, busy4, ov4, p4} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset4 ir/busy/ov/p=%b%b%b/%h want 100/00", ir4, busy4, ov4, p4);
      end
      checks++;
      if ({ir8, busy8, ov8, p8} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL reset8 ir/busy/ov/p=%b%b%b/%h want 100/0000", ir8, busy8, ov8, p8);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ir4, busy4, ov4} !== 3'b100) begin
         errors++;
         $display("FAIL post_reset4 ir/busy/ov=%b%b%b want 100", ir4, busy4, ov4);
      end
   endtask

   task automatic test_table4(input bit sm);
      logic [3:0] ta [4];
      logic [3:0] tb [4];
      logic [7:0] te [4];
      int cnt, n;
      bit ok;
      logic [7:0] exp;
      if (sm) begin
         ta = '{4'd8, 4'd8, 4'd10, 4'd3}; tb = '{4'd9, 4'd8, 4'd5, 4'd7};
         te = '{8'h38, 8'h40, 8'hE2, 8'h15}; cnt = 4;
      end else begin
         ta = '{4'd9, 4'd10, 4'd1, 4'd0}; tb = '{4'd15, 4'd5, 4'd0, 4'd0};
         te = '{8'h87, 8'h32, 8'h00, 8'h00}; cnt = 3;
      end
      or4 = 1'b1;
      for (int i = 0; i < cnt; i++) begin
         accept4(ta[i], tb[i], sm, te[i], 1'b0, ok);
         wait_out4(n);
         checks++;
         if (!ok || n !== 4) begin
            errors++;
            $display("FAIL lat4 sm=%0d #%0d accepted=%0d latency=%0d want 4", sm, i, ok, n);
         end
         exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
         checks++;
         if (p4 !== exp) begin
            errors++;
            $display("FAIL prod4 sm=%0d %0d*%0d p=%h want %h", sm, ta[i], tb[i], p4, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int n;
      bit ok;
      logic [7:0] exp;
      or4 = 1'b0;
      accept4(4'd3, 4'd7, 1'b0, 8'h15, 1'b0, ok);
      wait_out4(n);
      checks++;
      if (!ok || n !== 4) begin
         errors++;
         $display("FAIL bp_lat latency=%0d want 4", n);
      end
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         checks++;
         if ({ov4, ir4, p4} !== {1'b1, 1'b0, 8'h15}) begin
            errors++;
            $display("FAIL bp_hold cyc%0d ov/ir/p=%b%b/%h want 10/15", c, ov4, ir4, p4);
         end
      end
      exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
      or4 = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({ov4, ir4, p4} !== {1'b0, 1'b1, exp}) begin
         errors++;
         $display("FAIL bp_release ov/ir/p=%b%b/%h want 01/%h", ov4, ir4, p4, exp);
      end
   endtask

   task automatic test_input_hold();
      int n;
      bit ok;
      logic [7:0] exp;
      or4 = 1'b1;
      accept4(4'd5, 4'd3, 1'b0, 8'h0F, 1'b1, ok);
      a4 = 4'd6; b4 = 4'd7; sm4 = 1'b1;
      wait_out4(n);
      exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
      checks++;
      if (!ok || n !== 4 || p4 !== exp || ir4 !== 1'b0) begin
         errors++;
         $display("FAIL hold_first latency=%0d p=%h ir=%b want 4/%h/0", n, p4, ir4, exp);
      end
      sm4 = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({ir4, ov4, busy4} !== 3'b100) begin
         errors++;
         $display("FAIL hold_idle ir/ov/busy=%b%b%b want 100", ir4, ov4, busy4);
      end
      @(posedge clk); #1;
      iv4 = 1'b0;
      q4.push_back(8'h2A);
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b1) begin
         errors++;
         $display("FAIL hold_accept busy=%b want 1", busy4);
      end
      wait_out4(n);
      exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
      checks++;
      if (n !== 4 || p4 !== exp) begin
         errors++;
         $display("FAIL hold_second latency=%0d p=%h want 4/%h", n, p4, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int n;
      bit ok, seen;
      logic [7:0] exp;
      or4 = 1'b1;
      accept4(4'd9, 4'd9, 1'b0, 8'h51, 1'b0, ok);
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({ir4, busy4, ov4, p4} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL rst_mid ir/busy/ov/p=%b%b%b/%h want 100/00", ir4, busy4, ov4, p4);
      end
      q4.delete();
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ov4) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_output out_valid seen=%b want 0", seen);
      end
      accept4(4'd15, 4'd15, 1'b0, 8'hE1, 1'b0, ok);
      wait_out4(n);
      exp = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
      checks++;
      if (!ok || n !== 4 || p4 !== exp) begin
         errors++;
         $display("FAIL rst_next latency=%0d p=%h want 4/%h", n, p4, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sweep8();
      logic [7:0] corner [4];
      logic [7:0] ta, tb;
      logic [15:0] exp;
      logic tsm;
      int n;
      bit ok;
      corner = '{8'h00, 8'h7F, 8'h80, 8'hFF};
      or8 = 1'b1;
      for (int t = 0; t < 49; t++) begin
         if (t < 32) begin
            tsm = t[4]; ta = corner[t[3:2]]; tb = corner[t[1:0]];
            exp = model8(ta, tb, tsm);
         end else if (t == 32) begin
            tsm = 1'b1; ta = 8'h80; tb = 8'h80; exp = 16'h4000;
         end else begin
            tsm = 1'($urandom_range(0, 1));
            ta = 8'($urandom_range(0, 255)); tb = 8'($urandom_range(0, 255));
            exp = model8(ta, tb, tsm);
         end
         accept8(ta, tb, tsm, exp, ok);
         wait_out8(n);
         checks++;
         if (!ok || n !== 8) begin
            errors++;
            $display("FAIL lat8 #%0d accepted=%0d latency=%0d want 8", t, ok, n);
         end
         exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
         checks++;
         if (p8 !== exp) begin
            errors++;
            $display("FAIL prod8 #%0d sm=%0d %h*%h p=%h want %h", t, tsm, ta, tb, p8, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_table4(1'b0);
      test_table4(1'b1);
      test_backpressure();
      test_input_hold();
      test_reset_mid();
      test_sweep8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
